wbrouter_nx: RTL and testbench
==============================

WBROUTER_NX -- requirements
Module: wbrouter_nx

Interface
REQ-001 SHALL use one clock, clk; reset rst is asynchronous and active-low.
REQ-002 SHALL have parameter HAW, default 32: host address width.
REQ-003 SHALL have parameter DAW, default 28: device address width, DAW < HAW.
REQ-004 SHALL have parameter DW, default 32: data width; SW = DW/8 is a derived localparam.
REQ-005 SHALL have parameter NS, default 8, range 1..16: number of device ports.
REQ-006 SHALL have parameter MUXWIDTH, default 4: decode width taken from wb_host_addr[HAW-1 -: MUXWIDTH].
REQ-007 SHALL have parameter SLAVE_MUX, NS*MUXWIDTH bits: match value of device i in slice [i*MUXWIDTH +: MUXWIDTH].
REQ-008 SHALL have parameter TIMEOUT, default 255: cycles to wait for a device response; 0 disables the timeout.
REQ-009 clk  in  1  clock.
REQ-010 rst  in  1  async active-low reset.
REQ-011 wb_host_cyc / wb_host_stb / wb_host_we  in  1 each  host cycle, strobe and write enable.
REQ-012 wb_host_addr  in  HAW  host address.
REQ-013 wb_host_wdata  in  DW; wb_host_sel  in  SW.
REQ-014 wb_host_ack / wb_host_err  out  1 each  registered single-cycle responses.
REQ-015 wb_host_rdata  out  DW  registered read data.
REQ-016 wb_dev_cyc / wb_dev_stb / wb_dev_we  out  NS each  per-device bit i.
REQ-017 wb_dev_addr  out  NS*DAW; wb_dev_wdata  out  NS*DW; wb_dev_sel  out  NS*SW  packed, device i at slice i.
REQ-018 wb_dev_ack / wb_dev_err  in  NS each; wb_dev_rdata  in  NS*DW.

Function
REQ-019 SHALL implement a 4-state FSM: IDLE, BUSY, RESP, ERR, with one transaction outstanding (classic Wishbone).
REQ-020 IDLE with wb_host_cyc & wb_host_stb: decode; lowest-index matching device i SHALL be latched; next state is BUSY, or ERR if no device matches.
REQ-021 BUSY: wb_dev_cyc[i] and wb_dev_stb[i] SHALL be 1 from the cycle after the request until the response; addr[DAW-1:0], we, wdata and sel SHALL be registered at decode and held stable.
REQ-022 Non-selected devices SHALL see cyc=stb=0; their addr/wdata/sel are don't-care.
REQ-023 BUSY with wb_dev_ack[i] or wb_dev_err[i]: capture wb_dev_rdata slice i; drop dev cyc/stb in the same edge; go to RESP.
REQ-024 ack and err asserted together SHALL be treated as err.
REQ-025 RESP SHALL assert exactly one of wb_host_ack or wb_host_err for one cycle, then return to IDLE.
REQ-026 ERR SHALL assert wb_host_err for one cycle, with wb_host_rdata = 0, then return to IDLE.
REQ-027 TIMEOUT != 0: a BUSY-cycle counter, cleared on entry to BUSY, SHALL force ERR after TIMEOUT cycles without a response and drop dev cyc/stb.
REQ-028 Host drops wb_host_cyc while in BUSY: abort, drop dev cyc/stb next edge, go to IDLE, assert no ack or err.
REQ-029 A request in IDLE on the cycle after RESP/ERR SHALL be accepted as a new transaction.
REQ-030 Minimum latency SHALL be: request at cycle 0 -> dev stb at cycle 1 -> dev ack at cycle 1 -> host ack at cycle 2.

Reset
REQ-031 rst low SHALL asynchronously force IDLE, clear the counter and drive every output to 0; mid-transaction reset SHALL emit no ack or err.
REQ-032 Operation SHALL resume on the first clk rising edge after rst deasserts.

Structure
REQ-033 FSM state encoding and a clog2-based index-width function SHALL live in shared package wb_pkg.
REQ-034 Decode SHALL be sub-module wbrouter_decode, combinational: addr and SLAVE_MUX in, hit plus index out.

Verification
REQ-035 NS=8, SLAVE_MUX={7..0}; read at 0x3000_0010 with dev3 ack at cycle 1 and rdata 0xDEADBEEF -> dev_addr[3]=0x000_0010, host ack at cycle 2, rdata 0xDEADBEEF.
REQ-036 SLAVE_MUX with no entry 0xF; access 0xF000_0000 -> no dev cyc, host err 2 cycles after the request, rdata 0.
REQ-037 TIMEOUT=4; dev silent -> dev stb high exactly 4 cycles, then host err; no ack.
REQ-038 Dev5 asserts ack and err together -> host err only; back-to-back write follows the cycle after.
REQ-039 Host cyc drops in BUSY, or rst pulsed low in BUSY -> all dev cyc=0 next edge (immediately for rst); no host ack/err.
REQ-040 NS=3, MUXWIDTH=2, duplicate match values -> lowest index selected.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared router types: FSM state encoding
// and index-width helper.
package wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } wb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wbrouter_decode.sv
// Address-tag decoder: lowest-index device
// whose match value equals the tag wins.
module wbrouter_decode
  import wb_pkg::*;
#(
  parameter int NS       = 8,
  parameter int MUXWIDTH = 4,
  parameter logic [NS*MUXWIDTH-1:0] SLAVE_MUX = 32'h7654_3210,
  parameter int IW       = idx_width(NS)
) (
  input  logic [MUXWIDTH-1:0] addr_tag,
  output logic                hit,
  output logic [IW-1:0]       idx
);

  // scan high to low so the lowest match is the last one written
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (addr_tag == SLAVE_MUX[i*MUXWIDTH +: MUXWIDTH]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/wbrouter_nx.sv
// Classic Wishbone 1-to-NS router, one
// transaction outstanding, with timeout.
module wbrouter_nx
  import wb_pkg::*;
#(
  parameter int HAW      = 32,
  parameter int DAW      = 28,
  parameter int DW       = 32,
  parameter int NS       = 8,
  parameter int MUXWIDTH = 4,
  parameter logic [NS*MUXWIDTH-1:0] SLAVE_MUX = 32'h7654_3210,
  parameter int TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_host_cyc,
  input  logic             wb_host_stb,
  input  logic             wb_host_we,
  input  logic [HAW-1:0]   wb_host_addr,
  input  logic [DW-1:0]    wb_host_wdata,
  input  logic [DW/8-1:0]  wb_host_sel,
  output logic             wb_host_ack,
  output logic             wb_host_err,
  output logic [DW-1:0]    wb_host_rdata,
  output logic [NS-1:0]    wb_dev_cyc,
  output logic [NS-1:0]    wb_dev_stb,
  output logic [NS-1:0]    wb_dev_we,
  output logic [NS*DAW-1:0] wb_dev_addr,
  output logic [NS*DW-1:0]  wb_dev_wdata,
  output logic [NS*DW/8-1:0] wb_dev_sel,
  input  logic [NS-1:0]    wb_dev_ack,
  input  logic [NS-1:0]    wb_dev_err,
  input  logic [NS*DW-1:0] wb_dev_rdata
);

  localparam int SW = DW / 8;
  localparam int IW = idx_width(NS);
  localparam int TW = idx_width(TIMEOUT + 1);

  wb_state_e      state_q, state_d;
  logic           dec_hit;
  logic [IW-1:0]  dec_idx;
  logic           hit_q;
  logic [IW-1:0]  idx_q;
  logic [DAW-1:0] addr_q;
  logic           we_q;
  logic [DW-1:0]  wdata_q;
  logic [SW-1:0]  sel_q;
  logic [TW-1:0]  cnt_q;
  logic           ack_q;
  logic           err_q;
  logic [DW-1:0]  rdata_q;
  logic [NS-1:0]  dev_on;
  logic           req;
  logic           d_ack;
  logic           d_err;
  logic           tmo;
  logic           unused_addr;

  wbrouter_decode #(
    .NS       (NS),
    .MUXWIDTH (MUXWIDTH),
    .SLAVE_MUX(SLAVE_MUX),
    .IW       (IW)
  ) u_decode (
    .addr_tag(wb_host_addr[HAW-1 -: MUXWIDTH]),
    .hit     (dec_hit),
    .idx     (dec_idx)
  );

  assign unused_addr = ^wb_host_addr;
  assign req   = wb_host_cyc & wb_host_stb;
  assign d_ack = wb_dev_ack[idx_q];
  assign d_err = wb_dev_err[idx_q];
  assign tmo   = (TIMEOUT != 0) &&
                 (cnt_q == TW'(TIMEOUT - 1));

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // next state: a miss still spends one BUSY cycle with no device
  // strobed so that host err lands two cycles after the request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req) state_d = S_BUSY;
      S_BUSY: begin
        if (!wb_host_cyc)       state_d = S_IDLE;
        else if (!hit_q)        state_d = S_ERR;
        else if (d_ack | d_err) state_d = S_RESP;
        else if (tmo)           state_d = S_ERR;
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // request capture, timeout count and registered host response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q   <= 1'b0;
      idx_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      if (state_q == S_IDLE && req) begin
        hit_q   <= dec_hit;
        idx_q   <= dec_idx;
        addr_q  <= wb_host_addr[DAW-1:0];
        we_q    <= wb_host_we;
        wdata_q <= wb_host_wdata;
        sel_q   <= wb_host_sel;
        cnt_q   <= '0;
      end
      if (state_q == S_BUSY) begin
        if (TIMEOUT != 0) cnt_q <= cnt_q + TW'(1);
        if (state_d == S_RESP) begin
          ack_q   <= ~d_err;
          err_q   <= d_err;
          rdata_q <= wb_dev_rdata[int'(idx_q)*DW +: DW];
        end
        if (state_d == S_ERR) err_q <= 1'b1;
      end
    end
  end

  // one-hot device strobe while a hit transaction is in flight
  always_comb begin
    dev_on = '0;
    for (int i = 0; i < NS; i++) begin
      dev_on[i] = (state_q == S_BUSY) && hit_q &&
                  (idx_q == IW'(i));
    end
  end

  assign wb_dev_cyc    = dev_on;
  assign wb_dev_stb    = dev_on;
  assign wb_dev_we     = dev_on & {NS{we_q}};
  assign wb_dev_addr   = {NS{addr_q}};
  assign wb_dev_wdata  = {NS{wdata_q}};
  assign wb_dev_sel    = {NS{sel_q}};
  assign wb_host_ack   = ack_q;
  assign wb_host_err   = err_q;
  assign wb_host_rdata = rdata_q;

endmodule

// File: tb/tb_wbrouter_nx.sv
// Randomised self-checking bench for
// wbrouter_nx (8-port and 3-port builds).
module tb_wbrouter_nx;

  localparam int DW = 32;
  localparam logic [31:0] MUX_A = 32'h7654_3210;
  localparam logic [5:0]  MUX_B = 6'b01_01_10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 8-port build, TIMEOUT=4
  logic        h_cyc = 0, h_stb = 0, h_we = 0;
  logic [31:0] h_addr = '0, h_wdata = '0;
  logic [3:0]  h_sel = '0;
  logic        h_ack, h_err;
  logic [31:0] h_rdata;
  logic [7:0]  d_cyc, d_stb, d_we;
  logic [223:0] d_addr;
  logic [255:0] d_wdata;
  logic [31:0] d_sel;
  logic [7:0]  d_ack = '0, d_err = '0;
  logic [255:0] d_rdata = '0;

  wbrouter_nx #(
    .HAW(32), .DAW(28), .DW(32), .NS(8),
    .MUXWIDTH(4), .SLAVE_MUX(MUX_A), .TIMEOUT(4)
  ) u_dut (
    .clk(clk), .rst(rst),
    .wb_host_cyc(h_cyc), .wb_host_stb(h_stb),
    .wb_host_we(h_we), .wb_host_addr(h_addr),
    .wb_host_wdata(h_wdata), .wb_host_sel(h_sel),
    .wb_host_ack(h_ack), .wb_host_err(h_err),
    .wb_host_rdata(h_rdata),
    .wb_dev_cyc(d_cyc), .wb_dev_stb(d_stb),
    .wb_dev_we(d_we), .wb_dev_addr(d_addr),
    .wb_dev_wdata(d_wdata), .wb_dev_sel(d_sel),
    .wb_dev_ack(d_ack), .wb_dev_err(d_err),
    .wb_dev_rdata(d_rdata)
  );

  // 3-port build, duplicate match values, no timeout
  logic        b_cyc = 0, b_stb = 0;
  logic [31:0] b_addr = '0;
  logic        b_ack, b_err;
  logic [31:0] b_rdata;
  logic [2:0]  b_dcyc, b_dstb, b_dwe;
  logic [83:0] b_daddr;
  logic [95:0] b_dwdata;
  logic [11:0] b_dsel;
  logic [2:0]  b_dack;
  logic [95:0] b_drdata;
  logic        b_silent = 1'b0;

  assign b_dack = b_silent ? 3'b000 : (b_dcyc & b_dstb);

  always_comb begin
    b_drdata = '0;
    for (int i = 0; i < 3; i++)
      b_drdata[i*32 +: 32] = 32'hB000_0000 + i;
  end

  wbrouter_nx #(
    .HAW(32), .DAW(28), .DW(32), .NS(3),
    .MUXWIDTH(2), .SLAVE_MUX(MUX_B), .TIMEOUT(0)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .wb_host_cyc(b_cyc), .wb_host_stb(b_stb),
    .wb_host_we(1'b0), .wb_host_addr(b_addr),
    .wb_host_wdata(32'h0), .wb_host_sel(4'hF),
    .wb_host_ack(b_ack), .wb_host_err(b_err),
    .wb_host_rdata(b_rdata),
    .wb_dev_cyc(b_dcyc), .wb_dev_stb(b_dstb),
    .wb_dev_we(b_dwe), .wb_dev_addr(b_daddr),
    .wb_dev_wdata(b_dwdata), .wb_dev_sel(b_dsel),
    .wb_dev_ack(b_dack), .wb_dev_err(3'b000),
    .wb_dev_rdata(b_drdata)
  );

  // device responder for the 8-port build
  // mode: 0 ack, 1 err, 2 ack+err, 3 silent
  int          r_mode = 0;
  int          r_lat = 0;
  logic [31:0] r_data = '0;
  int          o_dev = -1;
  int          o_stb = 0;
  int          o_multi = 0;
  logic [27:0] o_addr;
  logic        o_we;
  logic [31:0] o_wdata;
  logic [3:0]  o_sel;

  always @(negedge clk) begin
    d_ack = '0;
    d_err = '0;
    for (int i = 0; i < 8; i++) d_rdata[i*32 +: 32] = ~r_data;
    if (d_cyc !== d_stb) o_multi++;
    if ($countones(d_cyc) > 1) o_multi++;
    for (int i = 0; i < 8; i++) begin
      if (d_cyc[i] && d_stb[i]) begin
        o_dev = i;
        o_stb++;
        o_addr  = d_addr[i*28 +: 28];
        o_we    = d_we[i];
        o_wdata = d_wdata[i*32 +: 32];
        o_sel   = d_sel[i*4 +: 4];
        if (o_stb > r_lat && r_mode != 3) begin
          d_rdata[i*32 +: 32] = r_data;
          d_ack[i] = (r_mode == 0) || (r_mode == 2);
          d_err[i] = (r_mode == 1) || (r_mode == 2);
        end
      end
    end
  end

  function automatic int dev_of_a(input logic [3:0] tag);
    logic [31:0] m;
    m = MUX_A;
    for (int i = 0; i < 8; i++)
      if (m[i*4 +: 4] == tag) return i;
    return -1;
  endfunction

  function automatic int dev_of_b(input logic [1:0] tag);
    logic [5:0] m;
    m = MUX_B;
    for (int i = 0; i < 3; i++)
      if (m[i*2 +: 2] == tag) return i;
    return -1;
  endfunction

  // one host transaction on the 8-port build; lat = cycles to response
  task automatic run_a(
    input  logic [31:0] addr, input logic we,
    input  logic [31:0] wd, input logic [3:0] sel,
    output int lat, output logic ack, output logic err,
    output logic [31:0] rd);
    @(posedge clk); #1;
    o_dev = -1; o_stb = 0; o_multi = 0;
    h_addr = addr; h_we = we; h_wdata = wd; h_sel = sel;
    h_cyc = 1'b1; h_stb = 1'b1;
    lat = -1; ack = 1'b0; err = 1'b0; rd = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (h_ack || h_err) begin
        lat = c; ack = h_ack; err = h_err; rd = h_rdata;
        break;
      end
    end
    h_cyc = 1'b0; h_stb = 1'b0; h_we = 1'b0;
  endtask

  task automatic run_b(
    input  logic [31:0] addr, output int lat,
    output logic ack, output logic err,
    output logic [31:0] rd, output logic [2:0] seen);
    @(posedge clk); #1;
    b_addr = addr; b_cyc = 1'b1; b_stb = 1'b1;
    lat = -1; ack = 1'b0; err = 1'b0; rd = '0; seen = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      seen |= b_dcyc & b_dstb;
      if (b_ack || b_err) begin
        lat = c; ack = b_ack; err = b_err; rd = b_rdata;
        break;
      end
    end
    b_cyc = 1'b0; b_stb = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({h_ack, h_err, h_rdata} !== 34'h0) begin
      errors++;
      $display("FAIL reset_host ack=%b err=%b rdata=%h want 0",
               h_ack, h_err, h_rdata);
    end
    checks++;
    if ({d_cyc, d_stb, d_we, d_addr, d_wdata, d_sel} !== '0) begin
      errors++;
      $display("FAIL reset_dev cyc=%h stb=%h addr=%h want 0",
               d_cyc, d_stb, d_addr);
    end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_read();
    int lat; logic ack, err; logic [31:0] rd;
    r_mode = 0; r_lat = 0; r_data = 32'hDEAD_BEEF;
    run_a(32'h3000_0010, 1'b0, 32'h0, 4'hF, lat, ack, err, rd);
    checks++;
    if (o_dev !== 3 || o_addr !== 28'h000_0010) begin
      errors++;
      $display("FAIL read_dev dev=%0d addr=%h want 3 0000010",
               o_dev, o_addr);
    end
    checks++;
    if (lat !== 2 || ack !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL read_lat lat=%0d ack=%b err=%b want 2 1 0",
               lat, ack, err);
    end
    checks++;
    if (rd !== 32'hDEAD_BEEF || o_multi !== 0) begin
      errors++;
      $display("FAIL read_data rdata=%h multi=%0d want deadbeef 0",
               rd, o_multi);
    end
  endtask

  task automatic test_miss();
    int lat; logic ack, err; logic [31:0] rd;
    r_mode = 0; r_lat = 0; r_data = 32'h1234_5678;
    run_a(32'hF000_0000, 1'b0, 32'h0, 4'hF, lat, ack, err, rd);
    checks++;
    if (o_dev !== -1 || o_stb !== 0) begin
      errors++;
      $display("FAIL miss_nodev dev=%0d stb=%0d want -1 0",
               o_dev, o_stb);
    end
    checks++;
    if (lat !== 2 || err !== 1'b1 || ack !== 1'b0 || rd !== 0) begin
      errors++;
      $display("FAIL miss_err lat=%0d ack=%b err=%b rd=%h want 2 0 1 0",
               lat, ack, err, rd);
    end
  endtask

  task automatic test_timeout();
    int lat; logic ack, err; logic [31:0] rd;
    r_mode = 3; r_data = 32'hCAFE_F00D;
    run_a(32'h2000_0004, 1'b0, 32'h0, 4'hF, lat, ack, err, rd);
    checks++;
    if (o_stb !== 4 || o_dev !== 2) begin
      errors++;
      $display("FAIL tmo_stb cycles=%0d dev=%0d want 4 2",
               o_stb, o_dev);
    end
    checks++;
    if (lat !== 5 || err !== 1'b1 || ack !== 1'b0 || rd !== 0) begin
      errors++;
      $display("FAIL tmo_err lat=%0d ack=%b err=%b rd=%h want 5 0 1 0",
               lat, ack, err, rd);
    end
  endtask

  task automatic test_ack_err_b2b();
    int lat; logic ack, err; logic [31:0] rd;
    r_mode = 2; r_lat = 1; r_data = 32'h5A5A_0005;
    run_a(32'h5000_0100, 1'b0, 32'h0, 4'hF, lat, ack, err, rd);
    checks++;
    if (o_dev !== 5 || lat !== 3 || ack !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL both_err dev=%0d lat=%0d ack=%b err=%b want 5 3 0 1",
               o_dev, lat, ack, err);
    end
    checks++;
    if (rd !== 32'h5A5A_0005) begin
      errors++;
      $display("FAIL both_rdata got=%h want 5a5a0005", rd);
    end
    r_mode = 0; r_lat = 0; r_data = 32'h0;
    run_a(32'h6000_0200, 1'b1, 32'h1357_9BDF, 4'hA, lat, ack, err, rd);
    checks++;
    if (o_dev !== 6 || lat !== 2 || ack !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_resp dev=%0d lat=%0d ack=%b err=%b want 6 2 1 0",
               o_dev, lat, ack, err);
    end
    checks++;
    if (o_we !== 1'b1 || o_wdata !== 32'h1357_9BDF ||
        o_sel !== 4'hA || o_addr !== 28'h000_0200) begin
      errors++;
      $display("FAIL b2b_write we=%b wd=%h sel=%h addr=%h want 1 13579bdf a 0000200",
               o_we, o_wdata, o_sel, o_addr);
    end
  endtask

  task automatic test_abort();
    int seen;
    r_mode = 3;
    @(posedge clk); #1;
    h_addr = 32'h1000_0000; h_we = 1'b0;
    h_cyc = 1'b1; h_stb = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (d_cyc !== 8'h02 || d_stb !== 8'h02) begin
      errors++;
      $display("FAIL abort_pre cyc=%h stb=%h want 02 02", d_cyc, d_stb);
    end
    h_cyc = 1'b0; h_stb = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (d_cyc !== 8'h00 || d_stb !== 8'h00) begin
      errors++;
      $display("FAIL abort_drop cyc=%h stb=%h want 00 00", d_cyc, d_stb);
    end
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (h_ack || h_err) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_resp responses=%0d want 0", seen);
    end
  endtask

  task automatic test_reset_busy();
    int seen;
    r_mode = 3;
    @(posedge clk); #1;
    h_addr = 32'h4000_0040; h_cyc = 1'b1; h_stb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (d_cyc !== 8'h10) begin
      errors++;
      $display("FAIL rstbusy_pre cyc=%h want 10", d_cyc);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (d_cyc !== 8'h00 || d_stb !== 8'h00 || h_ack || h_err) begin
      errors++;
      $display("FAIL rstbusy_drop cyc=%h stb=%h ack=%b err=%b want 0",
               d_cyc, d_stb, h_ack, h_err);
    end
    h_cyc = 1'b0; h_stb = 1'b0;
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (h_ack || h_err) seen++;
    end
    @(negedge clk) rst = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (h_ack || h_err) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rstbusy_resp responses=%0d want 0", seen);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int lat, exp;
      logic ack, err;
      logic [31:0] rd, addr, wd;
      logic [3:0] tag, sel;
      logic we;
      tag  = 4'($urandom_range(0, 11));
      addr = {tag, 28'($urandom)};
      wd   = $urandom;
      sel  = 4'($urandom);
      we   = 1'($urandom);
      r_mode = $urandom_range(0, 2);
      r_lat  = $urandom_range(0, 2);
      r_data = $urandom;
      exp = dev_of_a(tag);
      run_a(addr, we, wd, sel, lat, ack, err, rd);
      if (exp < 0) begin
        checks++;
        if (o_dev !== -1 || lat !== 2 || err !== 1'b1 ||
            ack !== 1'b0 || rd !== 0) begin
          errors++;
          $display("FAIL rnd_miss n=%0d dev=%0d lat=%0d ack=%b err=%b rd=%h",
                   n, o_dev, lat, ack, err, rd);
        end
      end else begin
        checks++;
        if (o_dev !== exp || o_addr !== addr[27:0] ||
            o_we !== we || o_wdata !== wd || o_sel !== sel ||
            o_multi !== 0) begin
          errors++;
          $display("FAIL rnd_req n=%0d dev=%0d/%0d addr=%h/%h we=%b/%b multi=%0d",
                   n, o_dev, exp, o_addr, addr[27:0], o_we, we, o_multi);
        end
        checks++;
        if (o_stb !== r_lat + 1 || lat !== r_lat + 2 ||
            ack !== (r_mode == 0) || err !== (r_mode != 0) ||
            rd !== r_data) begin
          errors++;
          $display("FAIL rnd_resp n=%0d stb=%0d lat=%0d ack=%b err=%b rd=%h want lat %0d mode %0d rd %h",
                   n, o_stb, lat, ack, err, rd, r_lat + 2, r_mode, r_data);
        end
      end
    end
  endtask

  task automatic test_lowest();
    logic [1:0] tags [4];
    tags[0] = 2'd1; tags[1] = 2'd2; tags[2] = 2'd0; tags[3] = 2'd3;
    foreach (tags[k]) begin
      int lat, exp;
      logic ack, err;
      logic [31:0] rd;
      logic [2:0] seen, want;
      exp = dev_of_b(tags[k]);
      want = (exp < 0) ? 3'b000 : 3'(1 << exp);
      run_b({tags[k], 30'h0000_0123}, lat, ack, err, rd, seen);
      checks++;
      if (seen !== want || lat !== 2 || ack !== (exp >= 0) ||
          err !== (exp < 0) ||
          rd !== ((exp < 0) ? 32'h0 : 32'hB000_0000 + exp)) begin
        errors++;
        $display("FAIL lowest tag=%0d seen=%b want=%b lat=%0d ack=%b err=%b rd=%h",
                 tags[k], seen, want, lat, ack, err, rd);
      end
    end
  endtask

  task automatic test_no_timeout();
    int bad;
    b_silent = 1'b1;
    @(posedge clk); #1;
    b_addr = 32'h4000_0000; b_cyc = 1'b1; b_stb = 1'b1;
    bad = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (b_ack || b_err) bad++;
    end
    checks++;
    if (bad !== 0 || b_dcyc !== 3'b010) begin
      errors++;
      $display("FAIL notmo responses=%0d cyc=%b want 0 010", bad, b_dcyc);
    end
    b_cyc = 1'b0; b_stb = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (b_dcyc !== 3'b000 || b_ack || b_err) begin
      errors++;
      $display("FAIL notmo_abort cyc=%b ack=%b err=%b want 000 0 0",
               b_dcyc, b_ack, b_err);
    end
    b_silent = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_miss();
    test_timeout();
    test_ack_err_b2b();
    test_abort();
    test_reset_busy();
    test_random();
    test_lowest();
    test_no_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
